// File: rtl/cache_block_ctrl.sv
// Valid/tag store plus miss-fill and flush-sweep sequencing for a 128-block direct-mapped cache.
// block_address feeds the external 7-to-128 decoder; block_we qualifies the decoded data-array write.
module cache_block_ctrl #(
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WOFF_W          = $clog2(WORDS_PER_BLOCK),
    parameter int TAG_W           = 32 - 7 - WOFF_W - 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              busy,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    output logic [6:0]        block_address,
    output logic              block_we,
    output logic [WOFF_W-1:0] fill_word
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state;
    logic [127:0]     valid;
    logic [TAG_W-1:0] tags [0:127];
    logic [TAG_W-1:0] fill_tag;
    logic [6:0]       fill_idx;
    logic [WOFF_W-1:0] beat;
    logic [6:0]       counter;
    logic             flush_pending;

    logic [6:0]       req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             last_beat;
    logic             unused_bits;

    assign req_idx     = req_addr[WOFF_W+8:WOFF_W+2];
    assign req_tag     = req_addr[31:WOFF_W+9];
    assign unused_bits = ^req_addr[WOFF_W+1:0];
    assign last_beat   = (beat == WOFF_W'(WORDS_PER_BLOCK - 1));
    assign hit         = (state == IDLE) && req_valid && valid[req_idx] && (tags[req_idx] == req_tag);

    always_comb begin
        // A flush waiting to be taken blocks service even for a hit.
        req_ready     = hit && !flush && !flush_pending;
        busy          = (state != IDLE);
        mem_req       = 1'b0;
        mem_addr      = '0;
        block_we      = 1'b0;
        fill_word     = '0;
        block_address = req_idx;
        case (state)
            FILL: begin
                mem_req       = 1'b1;
                mem_addr      = {fill_tag, fill_idx, beat, 2'b00};
                block_address = fill_idx;
                block_we      = mem_ack;
                fill_word     = mem_ack ? beat : '0;
            end
            FLUSH: block_address = counter;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            valid         <= '0;
            beat          <= '0;
            counter       <= '0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush || flush_pending) begin
                        state         <= FLUSH;
                        counter       <= '0;
                        flush_pending <= 1'b0;
                    end else if (req_valid && !hit) begin
                        state          <= FILL;
                        fill_tag       <= req_tag;
                        fill_idx       <= req_idx;
                        beat           <= '0;
                        valid[req_idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (flush)
                        flush_pending <= 1'b1;
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[fill_idx] <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (flush)
                        flush_pending <= 1'b1;
                    valid[counter] <= 1'b0;
                    counter        <= counter + 7'd1;
                    if (counter == 7'd127)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tags carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && state == FILL && mem_ack && last_beat)
            tags[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_cache_block_ctrl.sv
// Directed + randomized bench for cache_block_ctrl against an array-based valid/tag model.
module tb_cache_block_ctrl;

    localparam int WPB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [6:0]  block_address;
    logic        block_we;
    logic [1:0]  fill_word;

    int checks = 0;
    int errors = 0;

    logic [127:0] m_valid;
    logic [20:0]  m_tag [128];
    logic [31:0]  q_lines [$];

    cache_block_ctrl #(.WORDS_PER_BLOCK(WPB)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .busy(busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .block_address(block_address),
        .block_we(block_we), .fill_word(fill_word)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [31:0] addr);
        return m_valid[addr[10:4]] && (m_tag[addr[10:4]] == addr[31:11]);
    endfunction

    task automatic probe(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk("probe_ready", req_ready, model_hit(addr));
        req_valid = 1'b0;
        step();
    endtask

    task automatic post_reset_checks();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_block_we", block_we, 0);
        chk("rst_fill_word", fill_word, 0);
        chk("rst_ready", req_ready, 0);
        req_valid = 1'b0;
        step();
        foreach (q_lines[i]) probe(q_lines[i]);
    endtask

    // Entered at the first FLUSH cycle; returns early on a planted reset.
    task automatic sweep(input int reset_at, output logic was_reset);
        was_reset = 1'b0;
        for (int k = 0; k < 128; k++) begin
            mem_ack = 1'($urandom_range(0, 1));
            if (k == reset_at) reset = 1'b1;
            #1;
            chk("sweep_busy", busy, 1);
            chk("sweep_baddr", block_address, k);
            chk("sweep_we", block_we, 0);
            chk("sweep_mem_req", mem_req, 0);
            chk("sweep_ready", req_ready, 0);
            step();
            mem_ack = 1'b0;
            if (k == reset_at) begin
                reset     = 1'b0;
                m_valid   = '0;
                was_reset = 1'b1;
                return;
            end
        end
        m_valid = '0;
        #1;
        chk("sweep_done_busy", busy, 0);
    endtask

    task automatic flush_cmd(input logic with_req, input logic [31:0] addr, input int reset_at);
        logic r;
        flush     = 1'b1;
        req_valid = with_req;
        req_addr  = addr;
        #1;
        chk("flush_blocks_req", req_ready, 0);
        chk("flush_idle_busy", busy, 0);
        step();
        flush = 1'b0;
        sweep(reset_at, r);
        if (r) post_reset_checks();
    endtask

    // ack_mode: 0 every cycle, 1 every third cycle, 2 random.
    task automatic access(input logic [31:0] addr, input int ack_mode,
                          input int flush_beat, input int reset_beat);
        logic [6:0] idx;
        logic       exp_hit, ack, flushed, rst_now, r;
        int         beat, cyc;
        idx     = addr[10:4];
        exp_hit = model_hit(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk("idle_busy", busy, 0);
        chk("hit", req_ready, exp_hit);
        chk("idle_baddr", block_address, idx);
        step();
        if (exp_hit) begin
            req_valid = 1'b0;
            return;
        end
        q_lines.push_back(addr);
        beat = 0; cyc = 0; flushed = 1'b0;
        while (beat < WPB && cyc <= 100) begin
            case (ack_mode)
                0: ack = 1'b1;
                1: ack = (cyc % 3 == 2);
                default: ack = 1'($urandom_range(0, 1));
            endcase
            mem_ack = ack;
            flush   = (beat == flush_beat) && !flushed;
            if (flush) flushed = 1'b1;
            rst_now = (beat == reset_beat);
            reset   = rst_now;
            #1;
            chk("fill_mem_req", mem_req, 1);
            chk("fill_mem_addr", mem_addr, (addr & 32'hFFFF_FFF0) | (beat << 2));
            chk("fill_baddr", block_address, idx);
            chk("fill_we", block_we, ack);
            chk("fill_busy", busy, 1);
            chk("fill_ready", req_ready, 0);
            if (ack) chk("fill_word", fill_word, beat);
            step();
            flush   = 1'b0;
            mem_ack = 1'b0;
            if (rst_now) begin
                reset   = 1'b0;
                m_valid = '0;
                post_reset_checks();
                return;
            end
            if (ack) beat++;
            cyc++;
        end
        checks++;
        assert (cyc <= 100) else begin
            errors++;
            $error("FAIL fill_timeout cycles=%0d limit=100", cyc);
        end
        if (ack_mode == 0) chk("fill_cycles", cyc, WPB);
        if (ack_mode == 1) chk("fill_cycles_ws", cyc, 3 * WPB);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = addr[31:11];
        #1;
        chk("post_fill_busy", busy, 0);
        chk("post_fill_ready", req_ready, !flushed);
        if (flushed) begin
            step();
            req_valid = 1'b0;
            sweep(200, r);
        end else begin
            req_valid = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; mem_ack = 1'b0;
        m_valid = '0;
        repeat (3) step();
        req_addr = $urandom;
        #1;
        chk("reset_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_we", block_we, 0);
        chk("reset_fill_word", fill_word, 0);
        chk("reset_baddr", block_address, req_addr[10:4]);
        reset = 1'b0;
        step();

        access(32'h0000_1230, 0, -1, -1);
        access(32'h0000_1234, 0, -1, -1);
        access(32'h0004_1230, 0, -1, -1);
        access(32'h0000_1230, 0, -1, -1);
        access(32'h00AB_C5C0, 1, -1, -1);
        access(32'h00AB_C5C8, 1, -1, -1);

        mem_ack = 1'b1;
        repeat (3) begin
            #1;
            chk("idle_ack_busy", busy, 0);
            chk("idle_ack_we", block_we, 0);
            step();
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 40; n++) begin
            a = {9'd0, 12'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 4'($urandom)};
            access(a, 2 * int'($urandom_range(0, 1)), -1, -1);
        end

        access(32'h0000_2340, 0, 1, -1);
        foreach (q_lines[i]) probe(q_lines[i]);

        access(32'h0000_3450, 0, -1, -1);
        flush_cmd(1'b1, 32'h0000_3450, 200);
        access(32'h0000_3450, 0, -1, -1);
        probe(32'h0000_3450);

        access(32'h0000_5670, 0, -1, 2);
        access(32'h0000_6780, 0, -1, -1);
        flush_cmd(1'b0, 32'h0, 60);
        access(32'h0000_6780, 0, -1, -1);
        probe(32'h0000_6780);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_block_ctrl.md
# cache_block_ctrl

Miss-handling and flush controller for the 128-block direct-mapped cache. It holds the valid bits and tags and resolves hit/miss for CPU requests. On a miss it sequences a multi-word line fill from memory; on request it sweeps all 128 blocks to invalidate them. Its `block_address` output drives the 7-to-128 block decoder, whose one-hot output gates the data-array write enables qualified by `block_we`.

## Interface
- WORDS_PER_BLOCK, 4: words per line; power of two, 2..16; WOFF_W = log2(WORDS_PER_BLOCK)
- TAG_W, 32-7-WOFF_W-2 (21 at default): tag width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU access request; held with req_addr stable until req_ready
- req_addr  in  32  byte address; [1:0] byte, [WOFF_W+1:2] word, next 7 bits index, upper TAG_W bits tag
- req_ready  out  1  request served (hit) this cycle
- flush  in  1  single-cycle pulse: invalidate all blocks
- busy  out  1  state != IDLE
- mem_req  out  1  memory word read request
- mem_addr  out  32  word address of current fill beat
- mem_ack  in  1  one data word returned this cycle
- block_address  out  7  index to block decoder
- block_we  out  1  data-array write strobe for fill word
- fill_word  out  WOFF_W  word slot written when block_we=1

## Operation
- Storage: valid[127:0] (1 bit per block), tag[127:0] (TAG_W each).
- States: IDLE, FILL, FLUSH.
- IDLE:
  - block_address = req_addr index.
  - hit = req_valid & valid[idx] & (tag[idx] == req tag); req_ready = hit.
  - flush (or pending flush) has priority: go to FLUSH, counter = 0; a concurrent req is not served.
  - req_valid & !hit: latch req_addr line address, beat = 0, go to FILL.
- FILL:
  - mem_req = 1; mem_addr = {latched tag, index, beat, 2'b00}; block_address = latched index.
  - On mem_ack: block_we = 1, fill_word = beat, beat += 1.
  - valid[idx] cleared on FILL entry so a stale line is never reported hit.
  - On ack of beat WORDS_PER_BLOCK-1: tag[idx] written, valid[idx] set, go to IDLE.
- FLUSH:
  - block_address = counter; valid[counter] cleared; counter += 1 each cycle.
  - At counter = 127: clear, go to IDLE. block_we = 0 throughout.
- A flush pulse arriving in FILL or FLUSH sets flush_pending. It is consumed on the next IDLE cycle, so the in-flight fill always completes.
- Reset, including mid-FILL or mid-FLUSH:
  - state IDLE; all 128 valid bits cleared in the same edge; beat, counter and flush_pending cleared.
  - A fill interrupted by reset never sets valid. Tags are not reset.
- Reset values of outputs: req_ready 0, busy 0, mem_req 0, mem_addr 0, block_we 0, fill_word 0, block_address = req_addr index (combinational in IDLE).

## Timing
- Hit: req_ready combinational in the same cycle as req_valid; zero-wait.
- Miss, request first seen at edge t (IDLE):
  - FILL from t+1; mem_req high from t+1 until the cycle of the last ack, inclusive.
  - With ack every cycle, the last beat acks in cycle t+WORDS_PER_BLOCK and valid is set at that edge.
  - IDLE and req_ready=1 in cycle t+WORDS_PER_BLOCK+1 (t+5 at default).
- mem_ack wait states: mem_req and mem_addr hold; beat does not advance.
- mem_ack while not in FILL is ignored.
- FLUSH: exactly 128 cycles (busy high); IDLE on the 129th cycle after entry.
- block_we is coincident with mem_ack, and block_address is stable for the whole fill.

## Test plan
- Reset then cold access: req_addr 0x0000_1230 -> miss; mem_addr 0x1230, 0x1234, 0x1238, 0x123C with ack each cycle; block_address 0x23 during fill; fill_word 0..3; req_ready at cycle 5; a repeat access hits in 0 cycles.
- Conflict: fill 0x0000_1230, then access 0x0004_1230 (same index 0x23, different tag) -> miss and refill; a return to 0x1230 misses again.
- Wait states: ack only on every third cycle -> mem_addr holds per beat, exactly 4 block_we pulses, valid set only after the 4th.
- Flush during FILL at beat 1 -> fill completes; next cycle enters FLUSH; block_address walks 0..127; busy for 128 cycles; all prior lines then miss.
- Flush and req_valid in the same IDLE cycle -> FLUSH taken, req_ready stays 0 until after the sweep, then the request misses and fills.
- Reset asserted mid-FILL (beat 2) and mid-FLUSH (counter 60) -> next cycle: IDLE, mem_req 0, busy 0, every address misses.
